// File: rtl/mux_barrido.sv
// Scanned display multiplexer: selects one of CHANNELS data words (manual or auto-scan),
// registers the data, channel index and a one-hot anode enable that blanks on every channel change.
module mux_barrido #(
    parameter int WIDTH     = 4,
    parameter int CHANNELS  = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 2,
    localparam int SW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] datos_in,
    input  logic [SW-1:0]             select,
    input  logic                      modo,
    input  logic                      enable,
    output logic [WIDTH-1:0]          salida,
    output logic [SW-1:0]             canal,
    output logic [CHANNELS-1:0]       anodo
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    localparam logic [SW:0]   NCH    = (SW+1)'(CHANNELS);
    localparam logic [SW-1:0] CH_MAX = SW'(CHANNELS - 1);
    localparam logic [PW-1:0] PMAX   = PW'(DIV - 1);
    localparam logic [BW-1:0] BMAX   = BW'(BLANK_CYC - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [BW-1:0]         blank_q, blank_d;
    logic [SW-1:0]         canal_q, canal_d;
    logic [WIDTH-1:0]      salida_q, salida_d;
    logic [CHANNELS-1:0]   anodo_q, anodo_d;
    logic                  modo_prev_q;
    logic                  tc;

    logic [WIDTH-1:0] ch_dat [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_slice
        assign ch_dat[i] = datos_in[i*WIDTH +: WIDTH];
    end

    always_comb begin
        presc_d  = presc_q;
        canal_d  = canal_q;
        state_d  = state_q;
        blank_d  = blank_q;
        tc       = 1'b0;
        salida_d = ch_dat[canal_q];

        // A mode change restarts the scan period even while frozen.
        if (modo != modo_prev_q) begin
            presc_d = '0;
        end else if (enable) begin
            if (!modo) begin
                presc_d = '0;
            end else if (presc_q == PMAX) begin
                presc_d = '0;
                tc      = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (enable) begin
            if (!modo) begin
                if ({1'b0, select} < NCH) begin
                    canal_d = select;
                end
            end else if (tc) begin
                canal_d = (canal_q == CH_MAX) ? '0 : canal_q + SW'(1);
            end
        end

        if (!enable || (canal_d != canal_q)) begin
            state_d = BLANK;
            blank_d = '0;
        end else if (state_q == BLANK) begin
            if (blank_q == BMAX) begin
                state_d = SHOW;
                blank_d = '0;
            end else begin
                blank_d = blank_q + BW'(1);
            end
        end

        anodo_d = (state_d == SHOW) ? (CHANNELS'(1) << canal_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            presc_q     <= '0;
            blank_q     <= '0;
            canal_q     <= '0;
            salida_q    <= '0;
            anodo_q     <= '0;
            modo_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blank_q     <= blank_d;
            canal_q     <= canal_d;
            salida_q    <= salida_d;
            anodo_q     <= anodo_d;
            modo_prev_q <= modo;
        end
    end

    assign salida = salida_q;
    assign canal  = canal_q;
    assign anodo  = anodo_q;

endmodule
